// File: rtl/puf_pkg.sv
// Shared definitions for the PUF challenge sequencer: FSM state encoding,
// LFSR feedback polynomial and challenge address width.
package puf_pkg;

  localparam int          ADDR_W    = 10;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_AVAIL = 3'd2,
    CAPTURE    = 3'd3,
    EMIT       = 3'd4,
    SETTLE     = 3'd5,
    FINISH     = 3'd6
  } state_t;

  // Galois-style right shift; feedback taps applied when the outgoing bit is 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/popcount32.sv
// Combinational population count of a 32-bit word (result 0..32).
module popcount32 (
  input  logic [31:0] din,
  output logic [5:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 32; i++) begin
      count = count + {5'd0, din[i]};
    end
  end

endmodule

// File: rtl/challenge_seq.sv
// Challenge sequencer: issues LFSR-generated challenges to a PUF generator,
// waits for its responses and emits the write/clean difference and its weight.
module challenge_seq
  import puf_pkg::*;
#(
  parameter logic [31:0]       SEED           = 32'h2c77_d388,
  parameter logic [ADDR_W-1:0] ADDR_BASE      = 10'd0,
  parameter int                NUM_CHAL       = 16,
  parameter int                SETTLE_CYCLES  = 8,
  parameter int                TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        gen_enable,
  output logic [31:0] cha_data,
  output logic [31:0] cha_addr,
  input  logic        available,
  input  logic [31:0] rsp_write,
  input  logic [31:0] rsp_clean,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_idx,
  output logic [31:0] out_chal,
  output logic [31:0] out_diff,
  output logic [5:0]  out_hw
);

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [31:0]       SEED_INIT    = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam int                SETTLE_LEN   = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [31:0]       SETTLE_LAST  = 32'(SETTLE_LEN - 1);
  localparam logic [31:0]       TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        LAST_IDX     = 8'(NUM_CHAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE     = 1;

  state_t            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        idx_q, idx_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              terr_q, terr_d;
  logic [31:0]       rsp_w_q, rsp_w_d;
  logic [31:0]       rsp_c_q, rsp_c_d;
  logic [31:0]       diff_q, diff_d;
  logic [5:0]        hw_q, hw_d;
  logic [31:0]       diff_c;
  logic [5:0]        hw_c;

  assign diff_c = rsp_w_q ^ rsp_c_q;

  popcount32 u_popcount (
    .din   (diff_c),
    .count (hw_c)
  );

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    rsp_w_d = rsp_w_q;
    rsp_c_d = rsp_c_q;
    diff_d  = diff_q;
    hw_d    = hw_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          lfsr_d  = SEED_INIT;
          idx_d   = '0;
          addr_d  = ADDR_BASE;
          terr_d  = 1'b0;
        end
      end
      ISSUE: begin
        state_d = WAIT_AVAIL;
        cnt_d   = '0;
      end
      WAIT_AVAIL: begin
        if (available) begin
          rsp_w_d = rsp_write;
          rsp_c_d = rsp_clean;
          state_d = CAPTURE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          terr_d  = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      CAPTURE: begin
        diff_d  = diff_c;
        hw_d    = hw_c;
        state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            // Next challenge is prepared on the way into SETTLE.
            state_d = SETTLE;
            lfsr_d  = lfsr_step(lfsr_q);
            idx_d   = idx_q + 8'd1;
            addr_d  = addr_q + ADDR_ONE;
            cnt_d   = '0;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      rsp_w_q <= '0;
      rsp_c_q <= '0;
      diff_q  <= '0;
      hw_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      rsp_w_q <= rsp_w_d;
      rsp_c_q <= rsp_c_d;
      diff_q  <= diff_d;
      hw_q    <= hw_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign gen_enable  = (state_q == ISSUE) || (state_q == WAIT_AVAIL);
  assign out_valid   = (state_q == EMIT);
  assign timeout_err = terr_q;
  assign cha_data    = lfsr_q;
  assign cha_addr    = {{(32 - ADDR_W){1'b0}}, addr_q};
  assign out_idx     = idx_q;
  assign out_chal    = lfsr_q;
  assign out_diff    = diff_q;
  assign out_hw      = hw_q;

endmodule

// File: tb/tb_challenge_seq.sv
// Self-checking bench for challenge_seq: default instance (u_a) plus a
// wrap-around instance (u_b, ADDR_BASE=1022, NUM_CHAL=4, SETTLE_CYCLES=0).
module tb_challenge_seq;

  localparam logic [31:0] SEED = 32'h2c77_d388;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        start_a = 0, avail_a = 0, ready_a = 0;
  logic [31:0] rsp_w_a = 0, rsp_c_a = 0;
  logic        busy_a, done_a, terr_a, gen_a, ov_a;
  logic [31:0] cha_data_a, cha_addr_a, chal_a, diff_a;
  logic [7:0]  idx_a;
  logic [5:0]  hw_a;

  logic        start_b = 0, avail_b = 0, ready_b = 1;
  logic [31:0] rsp_w_b = 32'h1234_5678, rsp_c_b = 32'h0000_00ff;
  logic        busy_b, done_b, terr_b, gen_b, ov_b;
  logic [31:0] cha_data_b, cha_addr_b, chal_b, diff_b;
  logic [7:0]  idx_b;
  logic [5:0]  hw_b;

  challenge_seq u_a (
    .clk(clk), .resetn(resetn), .start(start_a), .busy(busy_a), .done(done_a),
    .timeout_err(terr_a), .gen_enable(gen_a), .cha_data(cha_data_a), .cha_addr(cha_addr_a),
    .available(avail_a), .rsp_write(rsp_w_a), .rsp_clean(rsp_c_a), .out_valid(ov_a),
    .out_ready(ready_a), .out_idx(idx_a), .out_chal(chal_a), .out_diff(diff_a), .out_hw(hw_a)
  );

  challenge_seq #(.ADDR_BASE(10'd1022), .NUM_CHAL(4), .SETTLE_CYCLES(0)) u_b (
    .clk(clk), .resetn(resetn), .start(start_b), .busy(busy_b), .done(done_b),
    .timeout_err(terr_b), .gen_enable(gen_b), .cha_data(cha_data_b), .cha_addr(cha_addr_b),
    .available(avail_b), .rsp_write(rsp_w_b), .rsp_clean(rsp_c_b), .out_valid(ov_b),
    .out_ready(ready_b), .out_idx(idx_b), .out_chal(chal_b), .out_diff(diff_b), .out_hw(hw_b)
  );

  // Reference: k-th challenge of a run is SEED advanced k times.
  function automatic logic [31:0] model_chal(input int k);
    logic [31:0] s;
    s = SEED;
    for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    return s;
  endfunction

  function automatic logic [31:0] model_addr(input int base, input int k);
    return 32'((base + k) % 1024);
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_a, done_a, gen_a, ov_a, terr_a} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy_a, done_a, gen_a, ov_a, terr_a});
    end
    checks++;
    if ({cha_data_a, cha_addr_a, idx_a, chal_a, diff_a, hw_a} !== '0) begin
      errors++; $display("FAIL reset_data: data %h addr %h idx %h chal %h diff %h hw %h want all 0",
                         cha_data_a, cha_addr_a, idx_a, chal_a, diff_a, hw_a);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // One challenge on u_a: respond after `delay` WAIT cycles, stall out_ready for `stall` cycles.
  task automatic do_chal_a(input int k, input int delay, input logic [31:0] w, input logic [31:0] c,
                           input int stall, input bit last);
    int n;
    logic [31:0] exp_c, exp_d;
    logic [5:0]  exp_hw;
    exp_c  = model_chal(k);
    exp_d  = w ^ c;
    exp_hw = 6'($countones(w ^ c));
    n = 0;
    while (gen_a !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (gen_a !== 1'b1) begin
      errors++; $display("FAIL gen_wait k=%0d: gen_enable %b want 1", k, gen_a); return;
    end
    checks++;
    if (cha_data_a !== exp_c) begin errors++; $display("FAIL cha_data k=%0d: got %h want %h", k, cha_data_a, exp_c); end
    checks++;
    if (cha_addr_a !== model_addr(0, k)) begin errors++; $display("FAIL cha_addr k=%0d: got %0d want %0d", k, cha_addr_a, model_addr(0, k)); end
    repeat (delay) begin
      @(negedge clk);
      checks++;
      if (gen_a !== 1'b1 || cha_data_a !== exp_c || ov_a !== 1'b0) begin
        errors++; $display("FAIL wait_stable k=%0d: gen %b data %h valid %b want 1 %h 0", k, gen_a, cha_data_a, ov_a, exp_c);
      end
    end
    avail_a = 1'b1; rsp_w_a = w; rsp_c_a = c;
    @(negedge clk);
    avail_a = 1'b0; rsp_w_a = $urandom; rsp_c_a = $urandom;
    checks++;
    if (ov_a !== 1'b0 || gen_a !== 1'b0) begin errors++; $display("FAIL capture k=%0d: valid %b gen %b want 0 0", k, ov_a, gen_a); end
    @(negedge clk);
    checks++;
    if (ov_a !== 1'b1) begin errors++; $display("FAIL latency k=%0d: out_valid %b want 1", k, ov_a); end
    checks++;
    if (idx_a !== 8'(k) || chal_a !== exp_c || diff_a !== exp_d || hw_a !== exp_hw) begin
      errors++; $display("FAIL result k=%0d: idx %0d chal %h diff %h hw %0d want %0d %h %h %0d",
                         k, idx_a, chal_a, diff_a, hw_a, k, exp_c, exp_d, exp_hw);
    end
    for (int s = 0; s < stall; s++) begin
      ready_a = 1'b0;
      start_a = (s == 1);
      avail_a = (s == 2);
      @(negedge clk);
      checks++;
      if (ov_a !== 1'b1 || gen_a !== 1'b0 || idx_a !== 8'(k) || chal_a !== exp_c || diff_a !== exp_d || hw_a !== exp_hw) begin
        errors++; $display("FAIL stall k=%0d s=%0d: valid %b gen %b idx %0d chal %h diff %h hw %0d", k, s, ov_a, gen_a, idx_a, chal_a, diff_a, hw_a);
      end
    end
    start_a = 1'b0; avail_a = 1'b0; ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    checks++;
    if (ov_a !== 1'b0 || done_a !== last) begin
      errors++; $display("FAIL transfer k=%0d: valid %b done %b want 0 %b", k, ov_a, done_a, last);
    end
  endtask

  task automatic test_main();
    int dly, stl;
    logic [31:0] w, c;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 16; k++) begin
      dly = (k < 2) ? 5 : int'($urandom_range(1, 8));
      stl = (k == 3) ? 20 : int'($urandom_range(0, 3));
      w = (k == 2) ? 32'hFFFF_0000 : $urandom;
      c = (k == 2) ? 32'h0F0F_0F0F : $urandom;
      do_chal_a(k, dly, w, c, stl, k == 15);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || terr_a !== 1'b0) begin
      errors++; $display("FAIL main_end: done %b busy %b terr %b want 0 0 0", done_a, busy_a, terr_a);
    end
  endtask

  task automatic test_wrap();
    int n;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (gen_b !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (gen_b !== 1'b1 || cha_addr_b !== model_addr(1022, k) || cha_data_b !== model_chal(k)) begin
        errors++; $display("FAIL wrap k=%0d: gen %b addr %0d data %h want 1 %0d %h", k, gen_b, cha_addr_b, cha_data_b, model_addr(1022, k), model_chal(k));
      end
      @(negedge clk);
      avail_b = 1'b1;
      @(negedge clk);
      avail_b = 1'b0;
    end
    n = 0;
    while (done_b !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (done_b !== 1'b1) begin errors++; $display("FAIL wrap_done: done %b want 1", done_b); end
    @(negedge clk);
    checks++;
    if (busy_b !== 1'b0 || done_b !== 1'b0) begin errors++; $display("FAIL wrap_idle: busy %b done %b want 0 0", busy_b, done_b); end
  endtask

  task automatic test_timeout();
    int n, gens, vals;
    n = 0; gens = 0; vals = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (done_a !== 1'b1 && n < 1200) begin
      if (gen_a === 1'b1) gens++;
      if (ov_a === 1'b1) vals++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_a !== 1'b1) begin errors++; $display("FAIL timeout_done: done %b after %0d cycles want 1", done_a, n); end
    checks++;
    if (terr_a !== 1'b1 || gen_a !== 1'b0) begin errors++; $display("FAIL timeout_flag: terr %b gen %b want 1 0", terr_a, gen_a); end
    checks++;
    if (vals != 0 || gens < 1024 || gens > 1026) begin
      errors++; $display("FAIL timeout_cycles: gen cycles %0d valid cycles %0d want 1024..1026 and 0", gens, vals);
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || terr_a !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: busy %b done %b terr %b want 0 0 1", busy_a, done_a, terr_a);
    end
  endtask

  task automatic test_midrun_reset();
    int n, dones;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (gen_a !== 1'b1 || terr_a !== 1'b0) begin errors++; $display("FAIL restart_run: gen %b terr %b want 1 0", gen_a, terr_a); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (gen_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL async_reset: gen %b busy %b done %b want 0 0 0", gen_a, busy_a, done_a);
    end
    @(negedge clk);
    resetn = 1'b1;
    dones = 0;
    repeat (5) begin @(negedge clk); if (done_a === 1'b1) dones++; end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL abort_done: %0d done pulses want 0", dones); end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (gen_a !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (gen_a !== 1'b1 || cha_data_a !== SEED || cha_addr_a !== 32'd0) begin
      errors++; $display("FAIL restart_seed: gen %b data %h addr %0d want 1 %h 0", gen_a, cha_data_a, cha_addr_a, SEED);
    end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_main();
    test_wrap();
    test_timeout();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
